mem_trace_monitor: RTL and testbench
====================================

// Module: mem_trace_monitor
// PURPOSE
//  Synthesisable bus monitor for the CPU data-memory port (address/data/write-enable from project).
//  Captures memory-write transactions into a parametrised ring buffer once an address trigger fires.
//  Stops capturing on a programmable halt address.
//  Entries drain through a valid/ready port, so benches and debug logic can check stores cycle by cycle.
// PARAMETERS
//  ADDR_W  16  bus address width
//  DATA_W  8   bus data width
//  DEPTH   16  trace entries; power of two, >=2
//  TS_W    16  timestamp width (used only with TRACE_TIMESTAMP_EN)
// PORTS
//  clk       in   1                  clock; all state changes on rising edge
//  reset     in   1                  asynchronous reset, active-low
//  arm       in   1                  pulse: flush buffer and start waiting for trigger
//  bus_adr   in   ADDR_W             monitored address (dataadr)
//  bus_data  in   DATA_W             monitored write data
//  bus_we    in   1                  monitored write enable (memwrite)
//  trg_adr   in   ADDR_W             trigger address
//  trg_mask  in   ADDR_W             1 = compare bit; all-zero mask triggers on any write
//  halt_adr  in   ADDR_W             write to this address ends capture
//  rd_valid  out  1                  head entry available
//  rd_ready  in   1                  consumer accepts head entry
//  rd_adr    out  ADDR_W             head entry address
//  rd_data   out  DATA_W             head entry data
//  rd_ts     out  TS_W               head entry timestamp (feature only)
//  level     out  $clog2(DEPTH+1)    entries held
//  overflow  out  1                  sticky: at least one write dropped
//  state     out  2                  mem_trace_pkg::state_t
// BEHAVIOUR
//  Reset: state=IDLE, level=0, rd_valid=0, overflow=0, rd_adr/rd_data/rd_ts=0, pointers=0, drop counter=0.
//  Trigger match: (bus_adr & trg_mask) == (trg_adr & trg_mask).
//  States and transitions:
//   IDLE -> ARMED on arm.
//   ARMED -> CAPTURE on bus_we && match.
//    The triggering write is itself pushed.
//    If it also hits halt_adr, go straight to DONE.
//   CAPTURE: every bus_we cycle pushes {bus_adr, bus_data[, ts]}.
//    bus_we && bus_adr==halt_adr pushes that write (if room), then -> DONE.
//   DONE -> ARMED on arm.
//  Arm handling:
//   arm in IDLE/DONE: flush (level=0, pointers=0), clear overflow and drop counter.
//   arm in ARMED: re-flush, stay ARMED.
//   arm in CAPTURE: ignored.
//  Latency:
//   A push on edge N makes rd_valid=1 after edge N.
//   Outputs are first-word-fall-through from the registered array; no combinational path from bus_* to rd_*.
//   Pop occurs on an edge where rd_valid && rd_ready.
//   Draining is legal in every state; DONE keeps data until drained or re-armed.
//  Full buffer (level==DEPTH):
//   A push without a same-cycle pop is dropped.
//   overflow<=1; 8-bit drop counter increments, saturating at 255.
//   Push and pop in the same cycle at full: both take effect, level unchanged, no drop.
//  Empty buffer: rd_valid=0; rd_ready ignored.
//   Push and pop cannot coincide at empty (rd_valid=0).
//  Pointers wrap modulo DEPTH; level never exceeds DEPTH.
//  arm in the same cycle as a push in ARMED: the flush wins and the push is discarded.
//  Reset asserted mid-operation: immediate return to reset values; buffer contents are unspecified but unreadable.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined:
//   Free-running TS_W-bit cycle counter, reset 0, wraps; it is not cleared by arm.
//   Each entry stores the counter value at the push edge; rd_ts presents the head entry's value.
//  TRACE_TIMESTAMP_EN undefined:
//   No counter and no timestamp storage; rd_ts is tied to 0.
// STRUCTURE
//  Package mem_trace_pkg:
//   state_t enum {IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3}.
//   Parametrised entry struct/typedef macro.
//   Constant DROP_MAX=8'd255.
//  Sub-module trace_fifo (DEPTH, entry width): show-ahead ring buffer with push/pop/flush, level, full/empty.
//  The top level holds the FSM, match logic, overflow/drop counter and timestamp.
// TESTING
//  1. reset low 2 cycles mid-CAPTURE -> state=0, level=0, rd_valid=0, overflow=0.
//  2. arm; trg_adr=16'h0040, mask=16'hFFFF; writes to 0x0010 then 0x0040=8'hA5
//     -> only {0040,A5} captured, state=CAPTURE, rd_valid one edge after the write.
//  3. DEPTH=16, rd_ready=0, 18 writes in CAPTURE -> level=16, overflow=1, drop count 2.
//     Same-cycle push+pop at full -> level stays 16, no drop.
//  4. halt_adr=16'h00FF; write 0x00FF=8'h3C -> entry captured, state=DONE.
//     Further writes ignored; drain all with rd_ready=1 -> entries in FIFO order, then rd_valid=0.
//  5. arm in CAPTURE -> ignored.
//     arm in DONE -> level=0, overflow=0, state=ARMED.
//     arm coinciding with a matching write in ARMED -> write discarded, state=ARMED.
//  6. With TRACE_TIMESTAMP_EN: writes at cycles 5 and 9 after reset -> rd_ts=5, then 9.
//     TS_W=4: writes spanning 16 cycles -> rd_ts wraps.
//     Without the macro: rd_ts==0 throughout.

Source files
------------

// File: rtl/mem_trace_pkg.sv
// Shared types and constants for the memory-write trace monitor.
package mem_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Width of one packed trace entry {ts, adr, data}; ts only when timestamps are built in.
  function automatic int entry_width(input int aw, input int dw, input int tw, input bit with_ts);
    return aw + dw + (with_ts ? tw : 0);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead ring buffer: head word is presented from the storage array, zero when empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // At full a push only fits when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/mem_trace_monitor.sv
// Bus monitor capturing triggered memory writes into a drainable trace buffer.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp with every entry.
module mem_trace_monitor
  import mem_trace_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [ADDR_W-1:0]          bus_adr,
  input  logic [DATA_W-1:0]          bus_data,
  input  logic                       bus_we,
  input  logic [ADDR_W-1:0]          trg_adr,
  input  logic [ADDR_W-1:0]          trg_mask,
  input  logic [ADDR_W-1:0]          halt_adr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_W-1:0]          rd_adr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [1:0]                 state,
  output logic [7:0]                 drop_cnt
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W, TS_W, 1'b1);
`else
  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W, TS_W, 1'b0);
`endif

  state_t             state_q, state_d;
  logic               push, flush, full, empty, pop_ok, drop;
  logic               trig_hit, halt_hit;
  logic               overflow_q;
  logic [7:0]         drop_cnt_q;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  assign trig_hit = ((bus_adr & trg_mask) == (trg_adr & trg_mask));
  assign halt_hit = (bus_adr == halt_adr);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          flush   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A flush beats a coincident trigger write.
        if (arm) begin
          flush = 1'b1;
        end else if (bus_we && trig_hit) begin
          push    = 1'b1;
          state_d = halt_hit ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus_we) begin
          push = 1'b1;
          if (halt_hit) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign pop_ok = rd_ready && !empty;
  assign drop   = push && full && !pop_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (flush) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign push_entry = {ts_q, bus_adr, bus_data};
  assign rd_ts      = head_entry[ADDR_W+DATA_W +: TS_W];
`else
  assign push_entry = {bus_adr, bus_data};
  assign rd_ts      = '0;
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (rd_ready),
    .din_i   (push_entry),
    .dout_o  (head_entry),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd_valid = !empty;
  assign rd_adr   = head_entry[DATA_W +: ADDR_W];
  assign rd_data  = head_entry[DATA_W-1:0];
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Randomised and directed bench for mem_trace_monitor against a queue-based reference model.
module tb_mem_trace_monitor;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;

  logic          clk = 1'b0;
  logic          reset, arm, bus_we, rd_ready;
  logic [AW-1:0] bus_adr, trg_adr, trg_mask, halt_adr;
  logic [DW-1:0] bus_data;
  logic          rd_valid, overflow;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;
  logic [TSW-1:0] rd_ts;
  logic [4:0]    level;
  logic [1:0]    state;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  mem_trace_monitor #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TSW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .bus_adr(bus_adr), .bus_data(bus_data),
    .bus_we(bus_we), .trg_adr(trg_adr), .trg_mask(trg_mask), .halt_adr(halt_adr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_adr(rd_adr), .rd_data(rd_data),
    .rd_ts(rd_ts), .level(level), .overflow(overflow), .state(state), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    logic [TSW-1:0] t;
  } ent_t;

  ent_t           mq[$];
  int             m_state;
  bit             m_ovf;
  int             m_drop;
  logic [TSW-1:0] m_ts;
  int             checks = 0;
  int             failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_ts    = '0;
  endtask

  // Reference behaviour for one clock edge, evaluated from the pre-edge inputs.
  task automatic model_step();
    bit   do_push = 1'b0;
    bit   do_flush = 1'b0;
    int   nxt = m_state;
    bit   hit_trg, hit_halt;
    ent_t e;
    hit_trg  = ((bus_adr & trg_mask) == (trg_adr & trg_mask));
    hit_halt = (bus_adr == halt_adr);
    case (m_state)
      0, 3: if (arm) begin do_flush = 1'b1; nxt = 1; end
      1: begin
        if (arm) do_flush = 1'b1;
        else if (bus_we && hit_trg) begin do_push = 1'b1; nxt = hit_halt ? 3 : 2; end
      end
      default: if (bus_we) begin do_push = 1'b1; if (hit_halt) nxt = 3; end
    endcase
    if (do_flush) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (mq.size() > 0 && rd_ready) begin
        e = mq.pop_front();
        $display("pop adr=%h data=%h ts=%0d", e.a, e.d, e.t);
      end
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back('{bus_adr, bus_data, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    m_state = nxt;
    m_ts    = m_ts + 1'b1;
  endtask

  task automatic check_all();
    check_val("state", 32'(state), 32'(m_state));
    check_val("level", 32'(level), 32'(mq.size()));
    check_val("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (mq.size() > 0) begin
      check_val("rd_adr", 32'(rd_adr), 32'(mq[0].a));
      check_val("rd_data", 32'(rd_data), 32'(mq[0].d));
`ifdef TRACE_TIMESTAMP_EN
      check_val("rd_ts", 32'(rd_ts), 32'(mq[0].t));
`else
      check_val("rd_ts", 32'(rd_ts), 32'd0);
`endif
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    arm = 1'b0; bus_we = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_we = 1'b1; bus_adr = a; bus_data = d;
    cycle();
    bus_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  // Assert reset asynchronously, check the reset state, hold two edges, release on a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_drop", 32'(drop_cnt), 32'd0);
    check_val("rst_adr", 32'(rd_adr), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'd0);
    check_val("rst_ts", 32'(rd_ts), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    bus_adr = '0; bus_data = '0;
    trg_adr = 16'h0040; trg_mask = 16'hFFFF; halt_adr = 16'h00FF;
    reset = 1'b0;
    #3;
    apply_reset();

    // Trigger: only the matching write is captured.
    pulse_arm();
    wr(16'h0010, 8'h11);
    check_val("t2_pre_valid", 32'(rd_valid), 32'd0);
    wr(16'h0040, 8'hA5);
    check_val("t2_valid", 32'(rd_valid), 32'd1);
    check_val("t2_adr", 32'(rd_adr), 32'h0040);
    check_val("t2_data", 32'(rd_data), 32'hA5);
    check_val("t2_state", 32'(state), 32'd2);

    // Overflow: 17 more writes without draining.
    for (int i = 0; i < 17; i++) wr(16'h0100 + 16'(i), 8'(i + 1));
    check_val("t3_level", 32'(level), 32'd16);
    check_val("t3_ovf", 32'(overflow), 32'd1);
    check_val("t3_drop", 32'(drop_cnt), 32'd2);
    rd_ready = 1'b1;
    wr(16'h0200, 8'h77);
    rd_ready = 1'b0;
    check_val("t3_pp_level", 32'(level), 32'd16);
    check_val("t3_pp_drop", 32'(drop_cnt), 32'd2);

    // arm in CAPTURE is ignored.
    pulse_arm();
    check_val("t5_cap_arm", 32'(state), 32'd2);

    // Halt write captured (with a same-edge pop to make room), then DONE ignores writes.
    rd_ready = 1'b1;
    wr(16'h00FF, 8'h3C);
    rd_ready = 1'b0;
    check_val("t4_state", 32'(state), 32'd3);
    for (int i = 0; i < 3; i++) wr(16'h0300 + 16'(i), 8'hEE);
    check_val("t4_ignored", 32'(level), 32'd16);
    rd_ready = 1'b1;
    while (level > 1 && rd_valid) cycle();
    check_val("t4_last", 32'(rd_data), 32'h3C);
    cycle();
    check_val("t4_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // arm in DONE flushes; arm with a matching write in ARMED discards it.
    pulse_arm();
    check_val("t5_done_state", 32'(state), 32'd1);
    check_val("t5_done_ovf", 32'(overflow), 32'd0);
    arm = 1'b1;
    wr(16'h0040, 8'h55);
    arm = 1'b0;
    check_val("t5_coin_state", 32'(state), 32'd1);
    check_val("t5_coin_level", 32'(level), 32'd0);

    // Reset in the middle of a capture.
    wr(16'h0040, 8'h01);
    wr(16'h0041, 8'h02);
    apply_reset();

    // Timestamps: writes in cycles 5 and 9 after reset release.
    trg_mask = 16'h0000;
    pulse_arm();
    repeat (4) cycle();
    wr(16'h0500, 8'h05);
    repeat (3) cycle();
    wr(16'h0900, 8'h09);
`ifdef TRACE_TIMESTAMP_EN
    check_val("t6_ts5", 32'(rd_ts), 32'd5);
`else
    check_val("t6_ts5", 32'(rd_ts), 32'd0);
`endif
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
    check_val("t6_ts9", 32'(rd_ts), 32'd9);
`else
    check_val("t6_ts9", 32'(rd_ts), 32'd0);
`endif

    // Random traffic over a narrow address window so triggers and halts occur often.
    for (int seg = 0; seg < 20; seg++) begin
      int rdy_pct;
      trg_adr  = 16'($urandom_range(0, 31));
      trg_mask = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'h001F;
      halt_adr = 16'($urandom_range(0, 31));
      rdy_pct  = $urandom_range(0, 100);
      for (int c = 0; c < 80; c++) begin
        arm      = ($urandom_range(0, 29) == 0);
        bus_we   = ($urandom_range(0, 1) == 1);
        bus_adr  = 16'($urandom_range(0, 31));
        bus_data = 8'($urandom);
        rd_ready = ($urandom_range(0, 99) < rdy_pct);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
